// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF   = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  localparam int DEFAULT_MEM_LATENCY = 2;
  localparam int CNT_W               = 4;

  // Choose among eligible requesters; on a tie data wins unless it had the last grant.
  function automatic grant_t pick_winner(input logic   if_elig,
                                         input logic   d_elig,
                                         input grant_t last_grant);
    if (if_elig && d_elig) begin
      return (last_grant == GRANT_DATA) ? GRANT_IF : GRANT_DATA;
    end else if (d_elig) begin
      return GRANT_DATA;
    end else begin
      return GRANT_IF;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_latency_counter.sv
// Down-counter that times the fixed memory latency; done is high at zero.
module mem_port_arbiter_latency_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  // Load takes priority; decrement stops at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between instruction fetch (read-only) and the
// data stage (read/write), one fixed-latency access at a time.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ARB_IDLE  | no access in flight; grant the first eligible request
//  ARB_ISSUE | mem_en strobe is out; load the latency counter
//  ARB_WAIT  | counting down; capture mem_rdata when the counter hits zero
//  ARB_RESP  | winner's ack is out; hand the port to the other requester
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter starts at MEM_LATENCY-1 in ISSUE so it reaches zero in the cycle
  // mem_rdata is valid.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_t state_q, state_d;
  grant_t     last_grant, grant_d;
  logic       grant_fire;
  logic       we_q;
  logic       resp_if_elig, resp_d_elig;
  logic       cnt_load, cnt_dec, cnt_done;
  logic       capture;
  logic       mem_en_d, mem_we_d, if_ack_d, d_ack_d;

  // In the ack cycle the winner's req is still high, so only the other side may win.
  assign resp_if_elig = if_req && (last_grant != GRANT_IF);
  assign resp_d_elig  = d_req  && (last_grant != GRANT_DATA);

  mem_port_arbiter_latency_counter #(.W(CNT_W)) u_lat_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and arbitration decision.
  always_comb begin
    state_d    = state_q;
    grant_d    = last_grant;
    grant_fire = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (if_req || d_req) begin
          grant_fire = 1'b1;
          grant_d    = pick_winner(if_req, d_req, last_grant);
          state_d    = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (cnt_done) begin
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (resp_if_elig || resp_d_elig) begin
          grant_fire = 1'b1;
          grant_d    = pick_winner(resp_if_elig, resp_d_elig, last_grant);
          state_d    = ARB_ISSUE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs and counter controls.
  always_comb begin
    mem_en_d = grant_fire;
    mem_we_d = grant_fire && (grant_d == GRANT_DATA) && d_we;
    cnt_load = (state_q == ARB_ISSUE);
    cnt_dec  = (state_q == ARB_WAIT);
    capture  = (state_q == ARB_WAIT) && cnt_done;
    if_ack_d = capture && (last_grant == GRANT_IF);
    d_ack_d  = capture && (last_grant == GRANT_DATA);
  end

  // Output registers, grant latch and read-data capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      last_grant <= GRANT_IF;
      we_q       <= 1'b0;
    end else begin
      mem_en <= mem_en_d;
      mem_we <= mem_we_d;
      if_ack <= if_ack_d;
      d_ack  <= d_ack_d;
      if (grant_fire) begin
        last_grant <= grant_d;
        we_q       <= mem_we_d;
        if (grant_d == GRANT_DATA) begin
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (capture && !we_q) begin
        if (last_grant == GRANT_IF) begin
          if_rdata <= mem_rdata;
        end else begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter at latencies 2, 1 and 15.
module tb_mem_port_arbiter;

  int   checks   = 0;
  int   failures = 0;
  logic clock    = 1'b0;

  always #5 clock = ~clock;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h8C220004;
  endfunction

  task automatic chk(input bit ok, input int lat, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL lat=%0d %s actual=0x%08h expected=0x%08h", lat, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT  = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    localparam int SLOT = LAT + 2;
    localparam int TMO  = 4 * SLOT + 8;

    logic        rst;
    logic        if_req, if_ack, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
      .clock(clock), .reset(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int cyc = 0;
    bit fin = 1'b0;

    // memory device: answers exactly LAT cycles after the strobe, junk otherwise
    bit          resp_pending;
    int          resp_cyc;
    logic [31:0] resp_data;
    logic [31:0] phys_mem [logic [31:0]];

    // reference model state
    bit          model_on;
    bit          exp_en, exp_win, outstanding, out_win, last_win;
    int          ack_cyc;
    logic [31:0] hold_addr;
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_d_read;

    // requester state
    bit if_busy, d_busy;
    int if_wait, d_wait, if_lat, d_lat;

    initial forever begin
      @(posedge clock);
      cyc++;
    end

    initial forever begin
      @(negedge clock);
      if (!rst && mem_en) begin
        if (mem_we) begin
          phys_mem[mem_addr] = mem_wdata;
        end else begin
          resp_pending = 1'b1;
          resp_cyc     = cyc + LAT;
          resp_data    = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : hash(mem_addr);
        end
      end
    end

    initial forever begin
      @(posedge clock);
      #1;
      if (resp_pending && cyc == resp_cyc) begin
        mem_rdata    = resp_data;
        resp_pending = 1'b0;
      end else begin
        mem_rdata = $urandom;
      end
    end

    // monitor: cycle-level timing/arbitration model plus data scoreboard
    initial forever begin
      bit          ack_now, e_if, e_d, w;
      logic [31:0] e;
      @(negedge clock);
      if (model_on) begin
        chk(mem_en == exp_en, LAT, "mem_en", 32'(mem_en), 32'(exp_en));
        if (mem_en && exp_en) begin
          chk(mem_addr == (exp_win ? d_addr : if_addr), LAT, "issue_addr", mem_addr,
              exp_win ? d_addr : if_addr);
          chk(mem_we == (exp_win && d_we), LAT, "issue_we", 32'(mem_we), 32'(exp_win && d_we));
          if (exp_win && d_we) chk(mem_wdata == d_wdata, LAT, "issue_wdata", mem_wdata, d_wdata);
          outstanding = 1'b1;
          out_win     = exp_win;
          ack_cyc     = cyc + 1 + LAT;
          hold_addr   = mem_addr;
        end else if (outstanding && cyc < ack_cyc) begin
          chk(mem_addr == hold_addr, LAT, "addr_hold", mem_addr, hold_addr);
        end
        ack_now = outstanding && (cyc == ack_cyc);
        chk(if_ack == (ack_now && !out_win), LAT, "if_ack", 32'(if_ack), 32'(ack_now && !out_win));
        chk(d_ack == (ack_now && out_win), LAT, "d_ack", 32'(d_ack), 32'(ack_now && out_win));
        if (if_ack) begin
          if (if_q.size() == 0) chk(1'b0, LAT, "if_ack_unexpected", 32'(if_ack), 0);
          else begin
            e = if_q.pop_front();
            chk(if_rdata == e, LAT, "if_rdata", if_rdata, e);
          end
        end
        if (d_ack) begin
          if (d_q.size() == 0) chk(1'b0, LAT, "d_ack_unexpected", 32'(d_ack), 0);
          else begin
            e = d_q.pop_front();
            chk(d_rdata == e, LAT, "d_rdata", d_rdata, e);
          end
        end
        chk(if_stall == (if_req && !if_ack), LAT, "if_stall", 32'(if_stall), 32'(if_req && !if_ack));
        chk(d_stall == (d_req && !d_ack), LAT, "d_stall", 32'(d_stall), 32'(d_req && !d_ack));
        if (ack_now) outstanding = 1'b0;
        e_if = if_req && !(ack_now && !out_win);
        e_d  = d_req && !(ack_now && out_win);
        if (!exp_en && !outstanding && (e_if || e_d)) begin
          w        = (e_if && e_d) ? !last_win : e_d;
          last_win = w;
          exp_win  = w;
          exp_en   = 1'b1;
        end else begin
          exp_en = 1'b0;
        end
      end
    end

    task automatic model_clear();
      exp_en       = 1'b0;
      outstanding  = 1'b0;
      last_win     = 1'b0;
      resp_pending = 1'b0;
      last_d_read  = '0;
      if_q.delete();
      d_q.delete();
      if_busy = 1'b0;
      d_busy  = 1'b0;
      if_req  = 1'b0;
      d_req   = 1'b0;
    endtask

    task automatic new_if(input logic [31:0] a);
      if_addr = a;
      if_busy = 1'b1;
      if_req  = 1'b1;
      if_wait = 0;
      if_q.push_back(hash(a));
    endtask

    task automatic new_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      d_busy  = 1'b1;
      d_req   = 1'b1;
      d_wait  = 0;
      if (we) begin
        ref_mem[a] = wd;
      end else begin
        last_d_read = ref_mem.exists(a) ? ref_mem[a] : hash(a);
      end
      d_q.push_back(last_d_read);
    endtask

    task automatic step(input int p_if, input int p_d);
      bit ifa, da;
      @(negedge clock);
      ifa = if_ack;
      da  = d_ack;
      @(posedge clock);
      #1;
      if (if_busy) begin
        if (ifa) begin
          if_busy = 1'b0;
          if_lat  = if_wait;
          chk(if_wait <= 2 * SLOT, LAT, "if_wait_bound", 32'(if_wait), 32'(2 * SLOT));
        end else begin
          if_wait++;
          if (if_wait > TMO) begin
            chk(1'b0, LAT, "if_ack_timeout", 32'(if_wait), 32'(TMO));
            if_busy = 1'b0;
          end
        end
      end
      if (d_busy) begin
        if (da) begin
          d_busy = 1'b0;
          d_lat  = d_wait;
          chk(d_wait <= 2 * SLOT, LAT, "d_wait_bound", 32'(d_wait), 32'(2 * SLOT));
        end else begin
          d_wait++;
          if (d_wait > TMO) begin
            chk(1'b0, LAT, "d_ack_timeout", 32'(d_wait), 32'(TMO));
            d_busy = 1'b0;
          end
        end
      end
      if (!if_busy && int'($urandom_range(0, 99)) < p_if)
        new_if(32'h4000 | (32'($urandom_range(0, 1023)) << 2));
      if (!d_busy && int'($urandom_range(0, 99)) < p_d)
        new_d(1'($urandom_range(0, 1)), 32'h1000 | (32'($urandom_range(0, 63)) << 2), $urandom);
      if_req = if_busy;
      d_req  = d_busy;
    endtask

    task automatic drain();
      for (int i = 0; i < TMO + 4 && (if_busy || d_busy); i++) step(0, 0);
      chk(!(if_busy || d_busy), LAT, "drain_idle", {30'b0, if_busy, d_busy}, 0);
    endtask

    task automatic zero_check(input string tag);
      chk({mem_en, mem_we, if_ack, d_ack} == 4'b0, LAT, {tag, "_strobes"},
          {28'b0, mem_en, mem_we, if_ack, d_ack}, 0);
      chk(mem_addr == 0, LAT, {tag, "_mem_addr"}, mem_addr, 0);
      chk(mem_wdata == 0, LAT, {tag, "_mem_wdata"}, mem_wdata, 0);
      chk(if_rdata == 0, LAT, {tag, "_if_rdata"}, if_rdata, 0);
      chk(d_rdata == 0, LAT, {tag, "_d_rdata"}, d_rdata, 0);
    endtask

    initial begin
      rst      = 1'b1;
      model_on = 1'b0;
      d_we     = 1'b0;
      if_addr  = '0;
      d_addr   = '0;
      d_wdata  = '0;
      model_clear();
      repeat (3) @(posedge clock);
      #1;
      zero_check("reset");
      rst      = 1'b0;
      model_on = 1'b1;

      new_if(32'h40);
      drain();
      chk(if_lat == SLOT, LAT, "lone_fetch_latency", 32'(if_lat), 32'(SLOT));

      new_if(32'h80);
      new_d(1'b0, 32'h100, 32'h0);
      drain();
      chk(d_lat == SLOT, LAT, "contend_d_latency", 32'(d_lat), 32'(SLOT));
      chk(if_lat == 2 * SLOT, LAT, "contend_if_latency", 32'(if_lat), 32'(2 * SLOT));

      new_d(1'b1, 32'h200, 32'hDEADBEEF);
      drain();
      chk(d_lat == SLOT, LAT, "store_latency", 32'(d_lat), 32'(SLOT));

      repeat (120) step(30, 30);
      repeat (120) step(100, 100);
      drain();

      new_d(1'b0, 32'h300, 32'h0);
      step(0, 0);
      step(0, 0);
      model_on = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      zero_check("async_reset");
      model_clear();
      @(posedge clock);
      @(posedge clock);
      #1;
      rst      = 1'b0;
      model_on = 1'b1;
      repeat (SLOT + 4) step(0, 0);
      new_if(32'h44);
      drain();
      chk(if_lat == SLOT, LAT, "post_reset_latency", 32'(if_lat), 32'(SLOT));
      model_on = 1'b0;
      fin      = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 60000 && !(lane[0].fin && lane[1].fin && lane[2].fin); i++)
      @(posedge clock);
    if (!(lane[0].fin && lane[1].fin && lane[2].fin)) begin
      checks++;
      failures++;
      $display("FAIL lanes_finished actual=%b%b%b expected=111",
               lane[2].fin, lane[1].fin, lane[0].fin);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
